// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// Optional feature macro: PLL_SUP_LOSS_CNT_EN (adds the lock-loss counter).
package pll_sup_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 16;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    HOLD_SYS,
    RUN,
    FAULT
  } state_t;

  // Width of the shared cycle counter: enough to hold the largest duration.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and system-side signals of the lock supervisor.
// lock_loss_cnt exists only when PLL_SUP_LOSS_CNT_EN is defined.
interface pll_sup_if;
  import pll_sup_pkg::*;

  logic               pll_lock;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_reset;
  logic               locked_ok;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
  logic [LOSS_W-1:0]  lock_loss_cnt;
`endif

  // The supervisor itself is the master: it sequences the PLL and the system reset.
  modport master (
    input  pll_lock, relock_req,
    output pll_rst, sys_reset, locked_ok, fault, retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
    , output lock_loss_cnt
`endif
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_rst, sys_reset, locked_ok, fault, retry_cnt
`ifdef PLL_SUP_LOSS_CNT_EN
    , input lock_loss_cnt
`endif
  );

endinterface

// File: rtl/pll_sup_sync.sv
// Two-flop synchronizer bringing the raw PLL lock into the reference clock domain.
module pll_sup_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses PLL reset, debounces lock, releases system reset.
// Define PLL_SUP_LOSS_CNT_EN to add the saturating lock-loss counter.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYSRST_HOLD_CYCLES  = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic     clock,
  input  logic     reset,
  pll_sup_if.master bus
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                   LOCK_TIMEOUT_CYCLES, SYSRST_HOLD_CYCLES);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(SYSRST_HOLD_CYCLES - 1);
  localparam logic [RETRY_W-1:0] MAX_R     = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [RETRY_W-1:0] retry_cnt, retry_nx, retry_inc;
  logic               pll_rst_q, sys_reset_q, locked_ok_q, fault_q;

  pll_sup_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_W'(1);

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;

    unique case (state)
      RESET_PLL: if (cnt == RST_LAST) state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
        end else if (cnt == TMO_LAST) begin
          retry_nx = retry_inc;
          state_nx = (retry_inc == MAX_R) ? FAULT : RESET_PLL;
        end
      end
      STABLE: begin
        if (!lock_s)               state_nx = WAIT_LOCK;
        else if (cnt == STB_LAST)  state_nx = HOLD_SYS;
      end
      HOLD_SYS: begin
        if (!lock_s)               state_nx = RESET_PLL;
        else if (cnt == HOLD_LAST) state_nx = RUN;
      end
      RUN:   if (!lock_s || bus.relock_req) state_nx = RESET_PLL;
      FAULT: begin
        if (bus.relock_req) begin
          state_nx = RESET_PLL;
          retry_nx = '0;
        end
      end
      default: state_nx = RESET_PLL;
    endcase

    if (state_nx == RUN) retry_nx = '0;

    // Counter parks at zero in RUN and FAULT, so it can never wrap.
    if (state_nx != state || state == RUN || state == FAULT) cnt_nx = '0;
    else                                                     cnt_nx = cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retry_cnt   <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      locked_ok_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      retry_cnt   <= retry_nx;
      pll_rst_q   <= (state_nx == RESET_PLL) || (state_nx == FAULT);
      sys_reset_q <= (state_nx != RUN);
      locked_ok_q <= (state_nx == RUN);
      fault_q     <= (state_nx == FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_reset = sys_reset_q;
  assign bus.locked_ok = locked_ok_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_cnt;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic              loss_event;
  logic [LOSS_W-1:0] loss_cnt;

  // Every RUN cycle with lock_s low is a RUN exit; a simultaneous relock_req is still one loss.
  assign loss_event = (state == RUN) && !lock_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         loss_cnt <= '0;
    else if (loss_event && loss_cnt != '1) loss_cnt <= loss_cnt + LOSS_W'(1);
  end

  assign bus.lock_loss_cnt = loss_cnt;
`endif

endmodule
